// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle between the pipeline datapath and the hazard control unit.
// The datapath (master) supplies register specifiers and stage status and
// receives the stall/flush controls, the timeout flag and the performance counters.
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdE;
    logic             RegWriteE;
    logic             LoadE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic             CntClr;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, RdE, RegWriteE, LoadE, PCSrcE, MemReqM, MemReadyM, CntClr,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  MemTimeout, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, RegWriteE, LoadE, PCSrcE, MemReqM, MemReadyM, CntClr,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output MemTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the five-stage RV32I pipeline.
// Resolves load-use bubbles, wrong-path squashes after taken branches/jumps and
// data-memory waits, and tracks long memory waits and hazard statistics.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hif
);
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } wait_state_t;

    wait_state_t       state_q;
    wait_state_t       state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic mem_wait;
    logic load_use;
    logic branch_flush;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;

    assign mem_wait     = hif.MemReqM & ~hif.MemReadyM;
    assign load_use     = hif.LoadE & hif.RegWriteE & (hif.RdE != 5'd0) &
                          ((hif.RdE == hif.Rs1D) | (hif.RdE == hif.Rs2D));
    assign branch_flush = hif.PCSrcE & ~mem_wait;

    // Prioritised stall/flush decode: memory wait freezes everything, then branch squash, then load-use bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            if (mem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (hif.PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign hif.StallF     = stall_f;
    assign hif.StallD     = stall_d;
    assign hif.StallE     = stall_e;
    assign hif.StallM     = stall_m;
    assign hif.FlushD     = flush_d;
    assign hif.FlushE     = flush_e;
    assign hif.FlushW     = flush_w;
    assign hif.MemTimeout = timeout_q;
    assign hif.StallCount = stall_cnt_q;
    assign hif.FlushCount = flush_cnt_q;

    // Memory-wait tracking: count consecutive wait cycles and latch the timeout once the limit is exceeded.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt_q == WAIT_MAX) begin
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Wait FSM state register; reset drops any wait in progress immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Saturating hazard counters; a clear request wins over counting in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hif.CntClr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (branch_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural reference model.
module tb_hazard_control_unit;
    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 4;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regw;
        logic       load;
        logic       pcsrc;
        logic       req;
        logic       rdy;
        logic       clr;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic [6:0] exp_ctl;
    } vec_t;

    logic clk;
    logic rst;

    hazard_control_unit_if #(.CNT_W(TB_CNT_W)) hif();

    hazard_control_unit #(
        .MEM_TIMEOUT(TB_TIMEOUT),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    int    n_vec  = 0;
    int    n_miss = 0;
    stim_t cur;
    int    m_run;
    bit    m_to;
    int    m_stall;
    int    m_flush;
    vec_t  tbl[12];

    // Free-running pipeline clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mkStim(int rs1, int rs2, int rd, bit regw, bit load,
                                     bit pcsrc, bit req, bit rdy, bit clr);
        stim_t s;
        s.rs1   = 5'(rs1);
        s.rs2   = 5'(rs2);
        s.rd    = 5'(rd);
        s.regw  = regw;
        s.load  = load;
        s.pcsrc = pcsrc;
        s.req   = req;
        s.rdy   = rdy;
        s.clr   = clr;
        return s;
    endfunction

    // Reference controls {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} from the hazard rules.
    function automatic logic [6:0] modelCtl(stim_t s);
        bit waiting;
        bit hazard;
        waiting = s.req && !s.rdy;
        hazard  = s.load && s.regw && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
        if (waiting) return 7'b1111_001;
        if (s.pcsrc) return 7'b0000_110;
        if (hazard)  return 7'b1100_010;
        return 7'b0000_000;
    endfunction

    function automatic logic [6:0] dutCtl();
        return {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_run   = 0;
        m_to    = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive a new input set half a cycle before the edge and let the combinational outputs settle.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur           = s;
        hif.Rs1D      = s.rs1;
        hif.Rs2D      = s.rs2;
        hif.RdE       = s.rd;
        hif.RegWriteE = s.regw;
        hif.LoadE     = s.load;
        hif.PCSrcE    = s.pcsrc;
        hif.MemReqM   = s.req;
        hif.MemReadyM = s.rdy;
        hif.CntClr    = s.clr;
        #1;
    endtask

    task automatic checkComb(input string name);
        checkOutput(name, 32'(dutCtl()), 32'(modelCtl(cur)));
    endtask

    // Advance through the rising edge, update the reference model and compare registered outputs.
    task automatic clockEdge();
        logic [6:0] ctl;
        bit waiting;
        ctl     = modelCtl(cur);
        waiting = cur.req && !cur.rdy;
        @(posedge clk);
        if (waiting) begin
            if (m_run >= TB_TIMEOUT) m_to = 1;
            m_run++;
        end else begin
            m_run = 0;
        end
        if (cur.clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (ctl[6] && m_stall < CNT_MAX) m_stall++;
            if (cur.pcsrc && !waiting && m_flush < CNT_MAX) m_flush++;
        end
        #1;
        checkOutput("stall_count", 32'(hif.StallCount), 32'(m_stall));
        checkOutput("flush_count", 32'(hif.FlushCount), 32'(m_flush));
        checkOutput("mem_timeout", 32'(hif.MemTimeout), 32'(m_to));
    endtask

    task automatic runCycle(input stim_t s, input string name);
        applyStimulus(s);
        checkComb(name);
        clockEdge();
    endtask

    // Assert reset part-way through the current cycle and release it on a later falling edge with idle inputs.
    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("reset_ctl", 32'(dutCtl()), 32'd0);
        checkOutput("reset_stall_count", 32'(hif.StallCount), 32'd0);
        checkOutput("reset_flush_count", 32'(hif.FlushCount), 32'd0);
        checkOutput("reset_timeout", 32'(hif.MemTimeout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cur           = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0);
        hif.Rs1D      = '0;
        hif.Rs2D      = '0;
        hif.RdE       = '0;
        hif.RegWriteE = 1'b0;
        hif.LoadE     = 1'b0;
        hif.PCSrcE    = 1'b0;
        hif.MemReqM   = 1'b0;
        hif.MemReadyM = 1'b0;
        hif.CntClr    = 1'b0;
        rst           = 1'b1;
        modelReset();
    endtask

    // Main test sequence.
    initial begin
        stim_t s;
        stim_t wt;
        int    saved;

        rst           = 1'b0;
        hif.Rs1D      = 5'd5;
        hif.Rs2D      = 5'd5;
        hif.RdE       = 5'd5;
        hif.RegWriteE = 1'b1;
        hif.LoadE     = 1'b1;
        hif.PCSrcE    = 1'b1;
        hif.MemReqM   = 1'b1;
        hif.MemReadyM = 1'b0;
        hif.CntClr    = 1'b0;
        #2;
        doReset();

        tbl[0]  = '{mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000_000};
        tbl[1]  = '{mkStim(1, 5, 5, 1, 1, 0, 0, 0, 0), 7'b1100_010};
        tbl[2]  = '{mkStim(7, 2, 7, 1, 1, 0, 0, 0, 0), 7'b1100_010};
        tbl[3]  = '{mkStim(0, 0, 0, 1, 1, 0, 0, 0, 0), 7'b0000_000};
        tbl[4]  = '{mkStim(3, 3, 3, 0, 1, 0, 0, 0, 0), 7'b0000_000};
        tbl[5]  = '{mkStim(3, 3, 3, 1, 0, 0, 0, 0, 0), 7'b0000_000};
        tbl[6]  = '{mkStim(1, 5, 5, 1, 1, 1, 0, 0, 0), 7'b0000_110};
        tbl[7]  = '{mkStim(0, 0, 0, 0, 0, 1, 0, 0, 0), 7'b0000_110};
        tbl[8]  = '{mkStim(1, 5, 5, 1, 1, 1, 1, 0, 0), 7'b1111_001};
        tbl[9]  = '{mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0), 7'b0000_000};
        tbl[10] = '{mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0000_000};
        tbl[11] = '{mkStim(4, 9, 9, 1, 1, 0, 1, 1, 0), 7'b1100_010};

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].in);
            checkOutput($sformatf("tbl%0d_ctl", i), 32'(dutCtl()), 32'(tbl[i].exp_ctl));
            clockEdge();
        end

        $display("[TB] memory wait with concurrent branch");
        saved = m_flush;
        wt    = mkStim(1, 5, 5, 1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(wt);
            checkOutput("memwait_ctl", 32'(dutCtl()), 32'(7'b1111_001));
            clockEdge();
        end
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0));
        checkOutput("memwait_release_ctl", 32'(dutCtl()), 32'd0);
        clockEdge();
        checkOutput("memwait_flush_count", 32'(hif.FlushCount), 32'(saved));

        $display("[TB] counter clear beats increment");
        runCycle(mkStim(1, 5, 5, 1, 1, 0, 0, 0, 1), "clr_ctl");
        checkOutput("clr_stall_count", 32'(hif.StallCount), 32'd0);

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 20; i++) begin
            runCycle(mkStim(6, 0, 6, 1, 1, 0, 0, 0, 0), "sat_ctl");
        end
        checkOutput("sat_stall_count", 32'(hif.StallCount), 32'(CNT_MAX));

        $display("[TB] memory timeout");
        runCycle(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), "to_idle");
        wt = mkStim(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) runCycle(wt, "to_wait_ctl");
        checkOutput("timeout_not_yet", 32'(hif.MemTimeout), 32'd0);
        runCycle(wt, "to_wait_ctl");
        checkOutput("timeout_set", 32'(hif.MemTimeout), 32'd1);
        runCycle(wt, "to_wait_ctl");
        runCycle(mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0), "to_release_ctl");
        runCycle(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), "to_idle");
        checkOutput("timeout_sticky", 32'(hif.MemTimeout), 32'd1);

        $display("[TB] reset during a memory wait");
        for (int i = 0; i < 4; i++) runCycle(wt, "rstw_ctl");
        applyStimulus(wt);
        checkComb("rstw_ctl");
        doReset();
        for (int i = 0; i < 4; i++) runCycle(wt, "rstw_after_ctl");
        checkOutput("rstw_count_restart", 32'(hif.MemTimeout), 32'd0);
        runCycle(wt, "rstw_after_ctl");
        checkOutput("rstw_timeout_again", 32'(hif.MemTimeout), 32'd1);
        runCycle(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), "rstw_idle");
        @(negedge clk);
        doReset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.regw  = ($urandom_range(0, 99) < 70);
            s.load  = ($urandom_range(0, 99) < 50);
            s.pcsrc = ($urandom_range(0, 99) < 15);
            s.req   = ($urandom_range(0, 99) < 40);
            s.rdy   = ($urandom_range(0, 99) < 40);
            s.clr   = ($urandom_range(0, 99) < 4);
            runCycle(s, "rand_ctl");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
